// File: rtl/wave_generator_dds_if.sv
`default_nettype none
// ============================================================================
//  Module      : wave_generator_dds_if
//  Description : Control/sample bundle for the DDS wave generator.
//                master : drives en, sw, freq_ctrl, duty, amp;
//                         observes wave_out, sync_out
//                slave  : the generator itself
//  Signals     : en        - 1 = phase accumulator advances
//                sw        - mode: 00 square, 01 triangle, 10 saw, 11 pulse
//                freq_ctrl - phase increment per clock (FCW_W bits)
//                duty      - pulse-mode high threshold (OUT_W bits)
//                amp       - amplitude scale (OUT_W bits)
//                wave_out  - registered output sample (OUT_W bits)
//                sync_out  - strobe on the first sample of each period
//  Revision    : 1.0 - initial release
// ============================================================================
interface wave_generator_dds_if #(
  parameter int OUT_W = 8,
  parameter int FCW_W = 16
);
  logic             en;
  logic [1:0]       sw;
  logic [FCW_W-1:0] freq_ctrl;
  logic [OUT_W-1:0] duty;
  logic [OUT_W-1:0] amp;
  logic [OUT_W-1:0] wave_out;
  logic             sync_out;

  modport master (
    output en, sw, freq_ctrl, duty, amp,
    input  wave_out, sync_out
  );

  modport slave (
    input  en, sw, freq_ctrl, duty, amp,
    output wave_out, sync_out
  );
endinterface
`default_nettype wire

// File: rtl/wave_generator_dds.sv
`default_nettype none
// ============================================================================
//  Module      : wave_generator_dds
//  Description : Phase-accumulator waveform generator. Produces square,
//                triangle, sawtooth or programmable-duty pulse samples with
//                runtime amplitude scaling. Mode, frequency, duty and
//                amplitude are held in active registers that only reload at
//                a period boundary (or while disabled / stalled), so changes
//                never cut a period short.
//  Ports       : clk_100kHz - system clock, rising edge
//                rst_       - asynchronous active-high reset
//                bus        - wave_generator_dds_if.slave (controls/samples)
//  Revision    : 1.0 - initial release
// ============================================================================
module wave_generator_dds #(
  parameter int OUT_W = 8,
  parameter int ACC_W = 16,
  parameter int FCW_W = 16
) (
  input  wire logic clk_100kHz,
  input  wire logic rst_,
  wave_generator_dds_if.slave bus
);

  localparam logic [1:0]       c_MODE_SQUARE = 2'b00;
  localparam logic [1:0]       c_MODE_TRI    = 2'b01;
  localparam logic [1:0]       c_MODE_SAW    = 2'b10;
  localparam logic [1:0]       c_MODE_PULSE  = 2'b11;
  localparam logic [OUT_W-1:0] c_MAX         = {OUT_W{1'b1}};
  localparam logic [OUT_W-1:0] c_HALF        = {1'b1, {(OUT_W-1){1'b0}}};
  localparam logic [FCW_W-1:0] c_FCW_RST     = FCW_W'(1);

  // Active (shadow) registers
  logic [1:0]       r_mode_a;
  logic [FCW_W-1:0] r_fcw_a;
  logic [OUT_W-1:0] r_duty_a;
  logic [OUT_W-1:0] r_amp_a;

  logic [ACC_W-1:0] r_acc;
  logic [OUT_W-1:0] r_wave;
  logic             r_wrap;
  logic             r_sync;

  logic [ACC_W:0]     w_sum;
  logic               w_wrap;
  logic               w_load;
  logic [OUT_W-1:0]   w_phase;
  logic [OUT_W-1:0]   w_tri;
  logic [OUT_W-1:0]   w_raw;
  logic [OUT_W:0]     w_amp_p1;
  logic [2*OUT_W:0]   w_prod;
  logic [OUT_W-1:0]   w_scaled;

  // One extra bit on the add exposes the carry that marks a period boundary.
  assign w_sum  = {1'b0, r_acc} + {{(ACC_W + 1 - FCW_W){1'b0}}, r_fcw_a};
  assign w_wrap = bus.en & w_sum[ACC_W];

  // Reload while disabled (track inputs), on a stalled zero increment
  // (otherwise a zero fcw could never be escaped), or on a wrap.
  assign w_load = ~bus.en | (r_fcw_a == '0) | w_wrap;

  assign w_phase = r_acc[ACC_W-1 -: OUT_W];
  assign w_tri   = {w_phase[OUT_W-2:0], 1'b0};

  always_comb begin
    w_raw = '0;
    case (r_mode_a)
      c_MODE_SQUARE: w_raw = w_phase[OUT_W-1] ? '0 : c_MAX;
      c_MODE_TRI:    w_raw = w_phase[OUT_W-1] ? ~w_tri : w_tri;
      c_MODE_SAW:    w_raw = w_phase;
      c_MODE_PULSE:  w_raw = (w_phase < r_duty_a) ? c_MAX : '0;
      default:       w_raw = '0;
    endcase
  end

  // raw * (amp+1) >> OUT_W : amp = MAX reproduces raw exactly, and the
  // result never exceeds MAX so the truncation to OUT_W bits is lossless.
  assign w_amp_p1 = {1'b0, r_amp_a} + (OUT_W + 1)'(1);
  assign w_prod   = {{(OUT_W + 1){1'b0}}, w_raw} * {{OUT_W{1'b0}}, w_amp_p1};
  assign w_scaled = OUT_W'(w_prod >> OUT_W);

  always_ff @(posedge clk_100kHz or posedge rst_) begin
    if (rst_) begin
      r_acc    <= '0;
      r_mode_a <= c_MODE_SQUARE;
      r_fcw_a  <= c_FCW_RST;
      r_duty_a <= c_HALF;
      r_amp_a  <= c_MAX;
      r_wave   <= '0;
      r_wrap   <= 1'b0;
      r_sync   <= 1'b0;
    end else begin
      if (bus.en) begin
        r_acc <= w_sum[ACC_W-1:0];
      end
      if (w_load) begin
        r_mode_a <= bus.sw;
        r_fcw_a  <= bus.freq_ctrl;
        r_duty_a <= bus.duty;
        r_amp_a  <= bus.amp;
      end
      r_wave <= w_scaled;
      // The wrap edge updates acc; the sample of that post-wrap phase
      // appears one edge later, so the strobe needs two stages.
      r_wrap <= w_wrap;
      r_sync <= r_wrap;
    end
  end

  assign bus.wave_out = r_wave;
  assign bus.sync_out = r_sync;

endmodule
`default_nettype wire

// File: tb/tb_wave_generator_dds.sv
`default_nettype none
`timescale 1ns/1ps
// ============================================================================
//  Module      : tb_wave_generator_dds
//  Description : Self-checking bench for wave_generator_dds. A reference
//                model predicts each registered sample from waveform rules;
//                predictions are queued and a monitor compares them with the
//                DUT after every rising clock edge.
//  Revision    : 1.0 - initial release
// ============================================================================
module tb_wave_generator_dds;

  localparam int OUT_W  = 8;
  localparam int ACC_W  = 16;
  localparam int FCW_W  = 16;
  localparam int MAXV   = (1 << OUT_W) - 1;
  localparam int HALF   = 1 << (OUT_W - 1);
  localparam int ACC_M  = 1 << ACC_W;

  typedef struct packed {
    logic [OUT_W-1:0] wave;
    logic             sync;
  } sample_t;

  logic clk_100kHz;
  logic rst_;

  wave_generator_dds_if #(.OUT_W(OUT_W), .FCW_W(FCW_W)) bus ();

  wave_generator_dds #(.OUT_W(OUT_W), .ACC_W(ACC_W), .FCW_W(FCW_W)) dut (
    .clk_100kHz (clk_100kHz),
    .rst_       (rst_),
    .bus        (bus.slave)
  );

  initial clk_100kHz = 1'b0;
  always #5 clk_100kHz = ~clk_100kHz;

  sample_t sb_q[$];
  int checks = 0;
  int errors = 0;

  // Reference model state
  int  m_phase;
  int  m_mode;
  int  m_fcw;
  int  m_duty;
  int  m_amp;
  bit  m_wrap_d;

  function automatic int ref_sample(int phase, int mode, int duty, int amp);
    int p;
    int raw;
    p = phase >> (ACC_W - OUT_W);
    case (mode)
      0:       raw = (p < HALF) ? MAXV : 0;
      1:       raw = (p < HALF) ? 2 * p : MAXV - 2 * (p - HALF);
      2:       raw = p;
      default: raw = (p < duty) ? MAXV : 0;
    endcase
    return (raw * (amp + 1)) >> OUT_W;
  endfunction

  task automatic model_reset();
    m_phase  = 0;
    m_mode   = 0;
    m_fcw    = 1;
    m_duty   = HALF;
    m_amp    = MAXV;
    m_wrap_d = 1'b0;
  endtask

  task automatic model_step(bit e, int s, int f, int d, int a);
    sample_t exp_s;
    bit wrap;
    exp_s.wave = OUT_W'(ref_sample(m_phase, m_mode, m_duty, m_amp));
    exp_s.sync = m_wrap_d;
    sb_q.push_back(exp_s);
    wrap = e && ((m_phase + m_fcw) >= ACC_M);
    if (e) m_phase = (m_phase + m_fcw) % ACC_M;
    if (!e || m_fcw == 0 || wrap) begin
      m_mode = s;
      m_fcw  = f % (1 << FCW_W);
      m_duty = d % (1 << OUT_W);
      m_amp  = a % (1 << OUT_W);
    end
    m_wrap_d = wrap;
  endtask

  // Drive one clock's worth of inputs at the falling edge and queue the
  // sample expected after the following rising edge.
  task automatic step(bit r, bit e, int s, int f, int d, int a);
    sample_t z;
    @(negedge clk_100kHz);
    rst_          = r;
    bus.en        = e;
    bus.sw        = 2'(s);
    bus.freq_ctrl = FCW_W'(f);
    bus.duty      = OUT_W'(d);
    bus.amp       = OUT_W'(a);
    if (r) begin
      model_reset();
      z.wave = '0;
      z.sync = 1'b0;
      sb_q.push_back(z);
    end else begin
      model_step(e, s, f, d, a);
    end
  endtask

  task automatic async_reset_check();
    sample_t z;
    @(negedge clk_100kHz);
    #2;
    rst_ = 1'b1;
    #1;
    checks++;
    if (bus.wave_out !== '0 || bus.sync_out !== 1'b0) begin
      errors++;
      $display("FAIL async_reset: wave_out=%0d sync_out=%0b, expected 0/0 at t=%0t",
               bus.wave_out, bus.sync_out, $time);
    end
    model_reset();
    z.wave = '0;
    z.sync = 1'b0;
    sb_q.push_back(z);
  endtask

  // Monitor: every rising edge presents a new registered sample.
  initial begin
    sample_t exp_s;
    forever begin
      @(posedge clk_100kHz);
      #1;
      if (sb_q.size() > 0) begin
        exp_s = sb_q.pop_front();
        checks++;
        if (bus.wave_out !== exp_s.wave || bus.sync_out !== exp_s.sync) begin
          errors++;
          if (errors <= 30)
            $display("FAIL sample: wave_out=%0d sync_out=%0b, expected wave_out=%0d sync_out=%0b at t=%0t",
                     bus.wave_out, bus.sync_out, exp_s.wave, exp_s.sync, $time);
        end
      end
    end
  end

  initial begin
    int s, f, d, a;
    bit e;
    int sel;

    rst_          = 1'b1;
    bus.en        = 1'b1;
    bus.sw        = '0;
    bus.freq_ctrl = '0;
    bus.duty      = '0;
    bus.amp       = '0;
    model_reset();

    // Reset held with random inputs and en=1
    repeat (5) step(1, 1, $urandom_range(3), $urandom_range(65535),
                    $urandom_range(255), $urandom_range(255));

    // Release into default square, then load sawtooth while disabled
    repeat (4) step(0, 1, 0, 1, HALF, MAXV);
    repeat (3) step(0, 0, 2, 256, HALF, 255);
    repeat (600) step(0, 1, 2, 256, HALF, 255);

    // Triangle (takes effect at next wrap)
    repeat (600) step(0, 1, 1, 256, HALF, 255);

    // Sawtooth, then switch to square mid-period
    repeat (356) step(0, 1, 2, 256, HALF, 255);
    repeat (400) step(0, 1, 0, 256, HALF, 255);

    // Pulse, duty 64, amp 127
    repeat (600) step(0, 1, 3, 256, 64, 127);

    // Sawtooth, pause mid-period for 50 cycles with a mode change while idle
    repeat (300) step(0, 1, 2, 256, HALF, 255);
    repeat (50)  step(0, 0, 2, 256, HALF, 255);
    repeat (10)  step(0, 0, 1, 256, HALF, 200);
    repeat (300) step(0, 1, 1, 256, HALF, 200);

    // Zero increment stall and recovery, full-scale increment
    repeat (5)   step(0, 0, 2, 0, HALF, 255);
    repeat (20)  step(0, 1, 2, 0, HALF, 255);
    repeat (300) step(0, 1, 2, 512, HALF, 255);
    repeat (40)  step(0, 1, 3, 65535, 100, 255);

    // Randomised operation
    s = 2; f = 300; d = 128; a = 255; e = 1'b1;
    repeat (3000) begin
      if ($urandom_range(15) == 0) begin
        s = $urandom_range(3);
        sel = $urandom_range(5);
        case (sel)
          0:       f = 0;
          1:       f = 65535;
          2:       f = 32768 + $urandom_range(32767);
          3:       f = 256;
          default: f = $urandom_range(2047);
        endcase
        sel = $urandom_range(3);
        d = (sel == 0) ? 0 : (sel == 1) ? MAXV : $urandom_range(255);
        a = (sel == 2) ? 0 : $urandom_range(255);
      end
      e = ($urandom_range(9) != 0);
      step(0, e, s, f, d, a);
    end

    // Asynchronous reset in the middle of a sawtooth period
    repeat (3)   step(0, 0, 2, 256, HALF, 255);
    repeat (150) step(0, 1, 2, 256, HALF, 255);
    async_reset_check();
    repeat (3)   step(1, 1, 2, 256, HALF, 255);
    repeat (3)   step(0, 0, 2, 256, HALF, 255);
    repeat (300) step(0, 1, 2, 256, HALF, 255);

    @(posedge clk_100kHz);
    #2;
    checks++;
    if (sb_q.size() != 0) begin
      errors++;
      $display("FAIL drain: %0d samples left unchecked, expected 0", sb_q.size());
    end

    $display("End of test - %0d assertions evaluated, %0d failures", checks, errors);
    $finish;
  end

endmodule
`default_nettype wire
